// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 16-bit words from a synchronous RAM, pulses Run once per
// instruction, prefetches the immediate of a move-immediate op, then waits for Done.
module instr_fetch_unit #(
    parameter int unsigned            ADDR_W     = 5,
    parameter logic [2:0]             MVI_OP     = 3'b001,
    parameter logic [ADDR_W-1:0]      START_ADDR = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [15:0]       instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAP, S_FETCH_I, S_CAP_I, S_ISSUE, S_DATA, S_WAIT
    } state_e;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         imm_q, imm_d;
    logic                is_mvi_q, is_mvi_d;
    logic [15:0]         din_q, din_d;
    logic                run_q, run_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                in_fetch;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        is_mvi_d = is_mvi_q;
        din_d    = din_q;
        cnt_d    = cnt_q;
        in_fetch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                in_fetch = 1'b1;
                pc_d     = pc_q + PC_ONE;
                state_d  = S_CAP;
            end
            S_CAP: begin
                in_fetch = 1'b1;
                instr_d  = mem_rdata;
                is_mvi_d = (mem_rdata[8:6] == MVI_OP);
                if (mem_rdata[8:6] == MVI_OP) begin
                    state_d = S_FETCH_I;
                end else begin
                    din_d   = mem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_I: begin
                in_fetch = 1'b1;
                pc_d     = pc_q + PC_ONE;
                state_d  = S_CAP_I;
            end
            S_CAP_I: begin
                in_fetch = 1'b1;
                imm_d    = mem_rdata;
                din_d    = instr_q;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                if (is_mvi_q) begin
                    din_d   = imm_q;
                    state_d = S_DATA;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DATA: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Done) state_d = Enable ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect discards any partially fetched word and restarts at the new PC.
        if (pc_load) begin
            pc_d = pc_value;
            if (in_fetch) begin
                state_d = S_FETCH;
                din_d   = din_q;
            end
        end

        run_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pc_q     <= START_ADDR;
            instr_q  <= '0;
            imm_q    <= '0;
            is_mvi_q <= 1'b0;
            din_q    <= '0;
            run_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            is_mvi_q <= is_mvi_d;
            din_q    <= din_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign DIN       = din_q;
    assign Run       = run_q;
    assign busy      = (state_q != S_IDLE);
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a RAM model feeds the unit, expected issues are
// queued as stimulus is applied and compared whenever Run fires.
module tb_instr_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        pc_load;
    logic [4:0]  pc_value;
    logic [4:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic [4:0]  pc;
    logic        busy;
    logic [15:0] instr_cnt;

    instr_fetch_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .DIN       (DIN),
        .Run       (Run),
        .Done      (Done),
        .pc        (pc),
        .busy      (busy),
        .instr_cnt (instr_cnt)
    );

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        bit          mvi;
    } exp_t;

    logic [15:0] ram [32];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          runs_seen = 0;
    bit          imm_pending = 0;
    bit          cnt_pending = 0;
    logic [15:0] exp_imm;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) mem_rdata <= ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input int addr);
        exp_t e;
        e.instr = ram[addr % 32];
        e.mvi   = (e.instr[8:6] == 3'b001);
        e.imm   = ram[(addr + 1) % 32];
        sb.push_back(e);
    endtask

    task automatic wait_run(output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            Done    = 1'b0;
            pc_load = 1'b0;
        end while (!Run && n < 40);
        chk("run_seen", Run, 1);
    endtask

    // Scoreboard side: every Run pops one expectation; the following cycle checks the immediate
    // (for MVI) and the issue counter.
    always @(negedge Clock) begin
        if (Reset) begin
            runs_seen   = 0;
            imm_pending = 0;
            cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                chk("instr_cnt", instr_cnt, runs_seen);
                cnt_pending = 0;
            end
            if (imm_pending) begin
                chk("din_imm", DIN, exp_imm);
                chk("run_one_cycle", Run, 0);
                imm_pending = 0;
            end
            if (Run) begin
                runs_seen++;
                cnt_pending = 1;
                chk("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("din_instr", DIN, e.instr);
                    if (e.mvi) begin
                        imm_pending = 1;
                        exp_imm     = e.imm;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;

        Reset = 1'b1; Enable = 1'b0; Done = 1'b0; pc_load = 1'b0; pc_value = '0;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0200 | 16'(i);
        ram[0]  = 16'h0010;
        ram[1]  = 16'h0040;
        ram[2]  = 16'h1234;
        ram[3]  = 16'h0280;
        ram[5]  = 16'h00AB;
        ram[31] = 16'h0040;

        repeat (2) @(negedge Clock);
        chk("rst_run", Run, 0);
        chk("rst_din", DIN, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_cnt", instr_cnt, 0);

        // Single-word instruction from address 0.
        push_exp(0);
        Enable = 1'b1;
        Reset  = 1'b0;
        wait_run(n);
        chk("lat_single", n, 3);
        chk("pc_single", pc, 1);
        chk("busy_issue", busy, 1);

        // Done held low: the unit must sit in WAIT.
        @(negedge Clock);
        extra = 0;
        repeat (20) begin
            @(negedge Clock);
            if (Run) extra++;
        end
        chk("no_run_in_wait", extra, 0);
        chk("busy_wait", busy, 1);
        chk("cnt_hold", instr_cnt, 1);

        // MVI at address 1 with immediate at address 2.
        push_exp(1);
        Done = 1'b1;
        wait_run(n);
        chk("lat_mvi", n, 5);
        chk("pc_mvi_issue", pc, 3);
        repeat (2) @(negedge Clock);
        chk("pc_after_mvi", pc, 3);

        push_exp(3);
        Done = 1'b1;
        wait_run(n);
        chk("lat_single2", n, 3);
        chk("pc_single2", pc, 4);
        @(negedge Clock);

        // Redirect from WAIT to the last address; immediate wraps to address 0.
        push_exp(31);
        pc_load = 1'b1; pc_value = 5'd31; Done = 1'b1;
        wait_run(n);
        chk("lat_wrap", n, 5);
        chk("pc_wrap", pc, 1);
        repeat (2) @(negedge Clock);

        // Redirect during CAP discards the word at address 1.
        push_exp(5);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        chk("addr_fetch", mem_addr, 1);
        @(negedge Clock);
        pc_load = 1'b1; pc_value = 5'd5;
        @(negedge Clock);
        pc_load = 1'b0;
        chk("cnt_discard", instr_cnt, 4);
        chk("addr_reload", mem_addr, 5);
        wait_run(n);
        chk("lat_reload", n, 2);
        chk("pc_reload", pc, 6);

        // Enable dropped mid-instruction: finish, then park in IDLE.
        Enable = 1'b0;
        @(negedge Clock);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        chk("busy_idle", busy, 0);
        extra = 0;
        repeat (5) begin
            @(negedge Clock);
            if (Run) extra++;
        end
        chk("no_run_idle", extra, 0);
        chk("pc_idle", pc, 6);
        push_exp(6);
        Enable = 1'b1;
        wait_run(n);
        chk("lat_from_idle", n, 3);
        @(negedge Clock);

        // Reset while fetching the immediate of the MVI at address 1.
        pc_load = 1'b1; pc_value = 5'd1; Done = 1'b1;
        @(negedge Clock);
        pc_load = 1'b0; Done = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("addr_fetch_i", mem_addr, 2);
        Reset = 1'b1;
        #1;
        chk("mid_rst_run", Run, 0);
        chk("mid_rst_din", DIN, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_cnt", instr_cnt, 0);
        sb.delete();
        repeat (2) @(negedge Clock);
        push_exp(0);
        Reset = 1'b0;
        wait_run(n);
        chk("lat_after_rst", n, 3);
        chk("pc_after_rst", pc, 1);
        repeat (2) @(negedge Clock);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
